// File: rtl/data_mem_unit.sv
// Data memory behind a posted write buffer with byte-wise store-to-load forwarding.
// Define DMEM_WBUF_EN to build the write buffer; otherwise stores write the array directly.
module data_mem_unit #(
  parameter int AW       = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemREAD,
  input  logic [1:0]                  MemWrite,
  input  logic [31:0]                 rd_data,
  input  logic [31:0]                 Read_data_2,
  output logic [31:0]                 data,
  output logic                        misalign_err,
  output logic [$clog2(WB_DEPTH):0]   wb_count
);

  localparam int PW = $clog2(WB_DEPTH);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  logic [31:0]   arr_rd;
  logic [31:0]   ld_word;
  logic [31:0]   wdat;
  logic [3:0]    strb;
  logic          mis;
  logic          st_ok;
  logic          drop;
  logic          unused_addr;

  assign idx         = rd_data[AW+1:2];
  assign arr_rd      = mem[idx];
  assign unused_addr = ^rd_data[31:AW+2];

  always_comb begin
    strb  = 4'b0000;
    wdat  = Read_data_2;
    mis   = 1'b0;
    unique case (1'b1)
      (MemWrite == 2'b01): begin
        strb = 4'b0001 << rd_data[1:0];
        wdat = {4{Read_data_2[7:0]}};
      end
      (MemWrite == 2'b10): begin
        mis  = rd_data[0];
        strb = rd_data[1] ? 4'b1100 : 4'b0011;
        wdat = {2{Read_data_2[15:0]}};
      end
      (MemWrite == 2'b11): begin
        mis  = |rd_data[1:0];
        strb = 4'b1111;
      end
      default: ;
    endcase
    st_ok = (MemWrite != 2'b00) && !mis;
  end

`ifdef DMEM_WBUF_EN
  logic [AW-1:0] wb_idx  [WB_DEPTH];
  logic [31:0]   wb_dat  [WB_DEPTH];
  logic [3:0]    wb_strb [WB_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [PW-1:0] pos;
  logic          full;
  logic          drain;
  logic          enq;

  // cnt clears asynchronously, so a reset mid-cycle also kills the drain
  assign full  = (cnt == (PW+1)'(WB_DEPTH));
  assign drain = !MemREAD && (cnt != '0);
  assign enq   = st_ok && (!full || drain);
  assign drop  = st_ok && full && !drain;

  always_comb begin
    ld_word = arr_rd;
    pos     = rd_ptr;
    for (int i = 0; i < WB_DEPTH; i++) begin
      pos = rd_ptr + PW'(i);
      if (((PW+1)'(i) < cnt) && (wb_idx[pos] == idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_strb[pos][b])
            ld_word[8*b +: 8] = wb_dat[pos][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (drain)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(enq) - (PW+1)'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx[wr_ptr]  <= idx;
      wb_dat[wr_ptr]  <= wdat;
      wb_strb[wr_ptr] <= strb;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_strb[rd_ptr][b])
          mem[wb_idx[rd_ptr]][8*b +: 8] <= wb_dat[rd_ptr][8*b +: 8];
      end
    end
  end

  assign wb_count = cnt;
`else
  assign ld_word  = arr_rd;
  assign drop     = 1'b0;
  assign wb_count = '0;

  always_ff @(posedge clk) begin
    if (st_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b])
          mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data         <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= mis || drop;
      if (MemREAD)
        data <= ld_word;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit; valid with or without DMEM_WBUF_EN.
// Expected load data comes from a flat byte-lane memory model.
module tb_data_mem_unit;

  logic        clk;
  logic        rst;
  logic        MemREAD;
  logic [1:0]  MemWrite;
  logic [31:0] rd_data;
  logic [31:0] Read_data_2;
  logic [31:0] data;
  logic        misalign_err;
  logic [2:0]  wb_count;

  logic [31:0] ref_mem [0:1023];
  int          passed;
  int          failed;
  int          total;

  data_mem_unit #(.AW(10), .WB_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemREAD      (MemREAD),
    .MemWrite     (MemWrite),
    .rd_data      (rd_data),
    .Read_data_2  (Read_data_2),
    .data         (data),
    .misalign_err (misalign_err),
    .wb_count     (wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit aligned(input logic [1:0] we, input logic [31:0] a);
    return (we == 2'd1) || (we == 2'd2 && !a[0]) ||
           (we == 2'd3 && a[1:0] == 2'd0);
  endfunction

  task automatic model_store(input logic [1:0] we, input logic [31:0] a,
                             input logic [31:0] d);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    case (we)
      2'd1: w[8*a[1:0] +: 8] = d[7:0];
      2'd2: w[16*a[1] +: 16] = d[15:0];
      2'd3: w = d;
      default: ;
    endcase
    if (we != 2'd0 && aligned(we, a))
      ref_mem[a[11:2]] = w;
  endtask

  task automatic cyc(input logic r, input logic [1:0] we,
                     input logic [31:0] a, input logic [31:0] d);
    MemREAD     = r;
    MemWrite    = we;
    rd_data     = a;
    Read_data_2 = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic do_store(input logic [1:0] we, input logic [31:0] a,
                          input logic [31:0] d);
    model_store(we, a, d);
    cyc(1'b0, we, a, d);
  endtask

  task automatic do_load(input logic [31:0] a, input string tag);
    logic [31:0] exp;
    exp = ref_mem[a[11:2]];
    cyc(1'b1, 2'd0, a, 32'd0);
    chk(tag, data, exp);
  endtask

  // load and store in the same cycle: load sees the pre-store view
  task automatic ld_st(input logic [1:0] we, input logic [31:0] a,
                       input logic [31:0] d, input bit apply,
                       input string tag);
    logic [31:0] exp;
    exp = ref_mem[a[11:2]];
    if (apply)
      model_store(we, a, d);
    cyc(1'b1, we, a, d);
    chk(tag, data, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    passed = 0;
    failed = 0;
    total  = 0;
    rst = 1'b1;
    MemREAD = 1'b0;
    MemWrite = 2'd0;
    rd_data = '0;
    Read_data_2 = '0;

    #2;
    chk("rst_data", data, 32'd0);
    chk("rst_wbcnt", 32'(wb_count), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++)
      do_store(2'd3, 32'(i * 4), 32'hA000_0000 | 32'(i));
    idle(4);
    chk("prefill_drained", 32'(wb_count), 32'd0);
    do_load(32'h10, "prefill_ld10");
    chk("prefill_const", data, 32'hA000_0004);

    do_store(2'd3, 32'h40, 32'hDEAD_BEEF);
    do_store(2'd1, 32'h41, 32'h0000_0055);
    do_load(32'h40, "fwd_ld40");
    chk("fwd_const", data, 32'hDEAD_55EF);
    idle(3);

    for (int i = 0; i < 4; i++)
      ld_st(2'd3, 32'h50 + 32'(i * 4), 32'h1111_0000 | 32'(i), 1'b1,
            "fill_ld");
`ifdef DMEM_WBUF_EN
    chk("fill_wbcnt4", 32'(wb_count), 32'd4);
`else
    chk("fill_wbcnt0", 32'(wb_count), 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      do_load(32'(i * 4), "stream_ld");
`ifdef DMEM_WBUF_EN
      chk("stream_wbcnt", 32'(wb_count), 32'd4);
`endif
    end
    idle(1);
`ifdef DMEM_WBUF_EN
    chk("after_idle_wbcnt3", 32'(wb_count), 32'd3);
`endif
    do_load(32'h5C, "fwd_ld5c");
    chk("fwd5c_const", data, 32'h1111_0003);

    ld_st(2'd3, 32'h60, 32'h2222_0000, 1'b1, "refill_ld");
    do_store(2'd3, 32'h80, 32'h1234_5678);
    chk("full_store_err", 32'(misalign_err), 32'd0);
`ifdef DMEM_WBUF_EN
    chk("full_store_wbcnt", 32'(wb_count), 32'd4);
`endif
    do_load(32'h80, "full_ld80");
    chk("full_ld80_const", data, 32'h1234_5678);
`ifdef DMEM_WBUF_EN
    ld_st(2'd3, 32'h84, 32'hFFFF_0000, 1'b0, "drop_ld");
    chk("drop_err", 32'(misalign_err), 32'd1);
    chk("drop_wbcnt", 32'(wb_count), 32'd4);
`else
    ld_st(2'd3, 32'h84, 32'hFFFF_0000, 1'b1, "drop_ld");
    chk("drop_err", 32'(misalign_err), 32'd0);
`endif
    idle(6);
    chk("drained_wbcnt", 32'(wb_count), 32'd0);
    chk("drained_err", 32'(misalign_err), 32'd0);
    do_load(32'h80, "drained_ld80");
    do_load(32'h84, "drained_ld84");
    do_load(32'h50, "drained_ld50");

    do_store(2'd2, 32'h43, 32'h0000_AAAA);
    chk("mis_half_err", 32'(misalign_err), 32'd1);
    do_store(2'd3, 32'h46, 32'hBBBB_BBBB);
    chk("mis_word_err", 32'(misalign_err), 32'd1);
    idle(1);
    chk("mis_err_clear", 32'(misalign_err), 32'd0);
    chk("mis_wbcnt", 32'(wb_count), 32'd0);
    idle(2);
    do_load(32'h40, "mis_ld40");
    do_load(32'h44, "mis_ld44");

`ifdef DMEM_WBUF_EN
    ld_st(2'd3, 32'h10, 32'hBADB_AD00, 1'b0, "rst_mid_ld");
`else
    ld_st(2'd3, 32'h10, 32'hBADB_AD00, 1'b1, "rst_mid_ld");
`endif
    MemREAD  = 1'b0;
    MemWrite = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_data", data, 32'd0);
    chk("rst_mid_wbcnt", 32'(wb_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_load(32'h10, "rst_ld10");

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 4));
      a  = 32'($urandom_range(0, 39)) * 4;
      d  = $urandom;
      case (op)
        0: do_load(a | 32'($urandom_range(0, 3)), "rand_ld");
        1: do_store(2'd1, a | 32'($urandom_range(0, 3)), d);
        2: do_store(2'd2, a | (32'($urandom_range(0, 1)) << 1), d);
        3: do_store(2'd3, a, d);
        default: idle(1);
      endcase
    end
    idle(6);
    for (int i = 0; i < 40; i += 3)
      do_load(32'(i * 4), "final_ld");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
